// File: rtl/pc_ras_unit.sv
// Program counter with an integrated circular return-address stack.
// Computes the next fetch PC and pushes/pops return addresses on call/return.
module pc_ras_unit #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PC_STEP  = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       PCWrite,
  input  logic [1:0]                 PCSrc,
  input  logic [WIDTH-1:0]           TargetIn,
  input  logic                       Call,
  input  logic                       RegWrite,
  input  logic [WIDTH-1:0]           AIn,
  output logic [WIDTH-1:0]           PCOut,
  output logic [WIDTH-1:0]           RaOut,
  output logic [$clog2(DEPTH+1)-1:0] Depth,
  output logic                       StackEmpty,
  output logic                       StackFull,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned DepthW = $clog2(DEPTH+1);

  localparam logic [1:0] SrcSeq = 2'b00;
  localparam logic [1:0] SrcRel = 2'b01;
  localparam logic [1:0] SrcAbs = 2'b10;
  localparam logic [1:0] SrcRet = 2'b11;

  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              wr_en;
  logic [PtrW-1:0]   wr_idx;
  logic [WIDTH-1:0]  wr_data;

  logic              empty, full;
  logic              do_push, do_pop;
  logic [WIDTH-1:0]  ret_addr;
  logic [WIDTH-1:0]  ra;
  logic [PtrW-1:0]   top_inc, top_dec;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DepthW'(DEPTH));
  assign ra       = empty ? '0 : mem_q[top_q];
  assign ret_addr = pc_q + WIDTH'(PC_STEP);
  assign do_push  = PCWrite && Call;
  assign do_pop   = PCWrite && (PCSrc == SrcRet);

  // Explicit wrap so non-power-of-two depths still form a proper ring.
  assign top_inc = (top_q == PtrW'(DEPTH-1)) ? '0 : top_q + 1'b1;
  assign top_dec = (top_q == '0) ? PtrW'(DEPTH-1) : top_q - 1'b1;

  always_comb begin
    pc_d = pc_q;
    if (PCWrite) begin
      unique case (PCSrc)
        SrcSeq:  pc_d = ret_addr;
        SrcRel:  pc_d = pc_q + TargetIn;
        SrcAbs:  pc_d = TargetIn;
        SrcRet:  pc_d = empty ? RESET_PC : mem_q[top_q];
        default: pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    top_d   = top_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    wr_data = ret_addr;

    if (do_push && do_pop) begin
      // Return and call together: replace top in place, depth unchanged.
      wr_en = 1'b1;
      if (empty) begin
        depth_d = DepthW'(1);
        unf_d   = 1'b1;
      end
    end else if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = top_inc;
      top_d  = top_inc;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + 1'b1;
      end
    end else if (do_pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - 1'b1;
        top_d   = top_dec;
      end
    end else if (RegWrite) begin
      wr_en   = 1'b1;
      wr_data = AIn;
      if (empty) begin
        depth_d = DepthW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      top_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; validity is tracked by depth_q.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign PCOut      = pc_q;
  assign RaOut      = ra;
  assign Depth      = depth_q;
  assign StackEmpty = empty;
  assign StackFull  = full;
  assign Overflow   = ovf_q;
  assign Underflow  = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit with hand-computed expectations.
module tb_pc_ras_unit;

  logic        CLK;
  logic        Reset;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic [15:0] TargetIn;
  logic        Call;
  logic        RegWrite;
  logic [15:0] AIn;
  logic [15:0] PCOut;
  logic [15:0] RaOut;
  logic [3:0]  Depth;
  logic        StackEmpty;
  logic        StackFull;
  logic        Overflow;
  logic        Underflow;

  int errors = 0;
  int checks = 0;

  pc_ras_unit dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .TargetIn  (TargetIn),
    .Call      (Call),
    .RegWrite  (RegWrite),
    .AIn       (AIn),
    .PCOut     (PCOut),
    .RaOut     (RaOut),
    .Depth     (Depth),
    .StackEmpty(StackEmpty),
    .StackFull (StackFull),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    PCWrite = 0; PCSrc = 2'b00; TargetIn = '0; Call = 0; RegWrite = 0; AIn = '0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1;
    #3;
    Reset = 0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    Reset = 1;
    #3;
    checks++; if (PCOut !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", PCOut); end
    checks++; if (Depth !== 4'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", Depth); end
    checks++; if (RaOut !== 16'h0000) begin errors++; $display("FAIL reset_ra got=%h exp=0000", RaOut); end
    checks++; if ({StackEmpty, StackFull, Overflow, Underflow} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got=%b exp=1000", {StackEmpty, StackFull, Overflow, Underflow});
    end
    Reset = 0;
    tick();
  endtask

  task automatic test_sequential();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0002; exp_seq[1] = 16'h0004; exp_seq[2] = 16'h0006;
    PCWrite = 1; PCSrc = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PCOut !== exp_seq[i]) begin
        errors++; $display("FAIL seq_%0d got=%h exp=%h", i, PCOut, exp_seq[i]);
      end
    end
    PCWrite = 0;
    tick();
    checks++; if (PCOut !== 16'h0006) begin errors++; $display("FAIL seq_hold got=%h exp=0006", PCOut); end
  endtask

  task automatic test_call_return();
    do_reset();
    PCWrite = 1; PCSrc = 2'b10; TargetIn = 16'h0010;
    tick();
    Call = 1; TargetIn = 16'h0100;
    tick();
    checks++; if (PCOut !== 16'h0100) begin errors++; $display("FAIL call_pc got=%h exp=0100", PCOut); end
    checks++; if (RaOut !== 16'h0012) begin errors++; $display("FAIL call_ra got=%h exp=0012", RaOut); end
    checks++; if (Depth !== 4'd1) begin errors++; $display("FAIL call_depth got=%0d exp=1", Depth); end
    Call = 0; PCSrc = 2'b11;
    tick();
    checks++; if (PCOut !== 16'h0012) begin errors++; $display("FAIL ret_pc got=%h exp=0012", PCOut); end
    checks++; if (Depth !== 4'd0 || StackEmpty !== 1'b1) begin
      errors++; $display("FAIL ret_empty got depth=%0d empty=%b exp depth=0 empty=1", Depth, StackEmpty);
    end
    idle();
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] exp_ret [9];
    logic [15:0] exp_pc;
    do_reset();
    exp_pc = 16'h0000;
    PCWrite = 1; PCSrc = 2'b10; Call = 1;
    for (int i = 0; i < 9; i++) begin
      exp_ret[i] = exp_pc + 16'h0002;
      TargetIn = 16'h1000 + 16'(i * 16);
      tick();
      exp_pc = TargetIn;
    end
    Call = 0;
    checks++; if (Depth !== 4'd8 || StackFull !== 1'b1) begin
      errors++; $display("FAIL full got depth=%0d full=%b exp depth=8 full=1", Depth, StackFull);
    end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL overflow got=%b exp=1", Overflow); end
    PCSrc = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (PCOut !== exp_ret[8-k]) begin
        errors++; $display("FAIL pop_%0d got=%h exp=%h", k, PCOut, exp_ret[8-k]);
      end
    end
    checks++; if (Depth !== 4'd0 || Underflow !== 1'b0) begin
      errors++; $display("FAIL drained got depth=%0d unf=%b exp depth=0 unf=0", Depth, Underflow);
    end
    tick();
    checks++; if (PCOut !== 16'h0000 || Underflow !== 1'b1) begin
      errors++; $display("FAIL underflow got pc=%h unf=%b exp pc=0000 unf=1", PCOut, Underflow);
    end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", Overflow); end
    idle();
  endtask

  task automatic test_async_reset();
    PCWrite = 1; PCSrc = 2'b10; TargetIn = 16'h0ABC; Call = 1;
    tick();
    idle();
    checks++; if (PCOut !== 16'h0ABC || Depth !== 4'd1) begin
      errors++; $display("FAIL pre_areset got pc=%h depth=%0d exp pc=0abc depth=1", PCOut, Depth);
    end
    #2;
    Reset = 1;
    #1;
    checks++; if (PCOut !== 16'h0000 || RaOut !== 16'h0000 || Depth !== 4'd0) begin
      errors++; $display("FAIL areset_state got pc=%h ra=%h depth=%0d exp 0000 0000 0", PCOut, RaOut, Depth);
    end
    checks++; if ({StackEmpty, StackFull, Overflow, Underflow} !== 4'b1000) begin
      errors++; $display("FAIL areset_flags got=%b exp=1000", {StackEmpty, StackFull, Overflow, Underflow});
    end
    #1;
    Reset = 0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    PCWrite = 1; PCSrc = 2'b10; TargetIn = 16'hFFFE;
    tick();
    PCSrc = 2'b01; TargetIn = 16'h0004;
    tick();
    checks++; if (PCOut !== 16'h0002) begin errors++; $display("FAIL wrap_fwd got=%h exp=0002", PCOut); end
    PCSrc = 2'b10; TargetIn = 16'h0010;
    tick();
    PCSrc = 2'b01; TargetIn = 16'hFFF0;
    tick();
    checks++; if (PCOut !== 16'h0000) begin errors++; $display("FAIL wrap_back got=%h exp=0000", PCOut); end
    idle();
  endtask

  task automatic test_regwrite();
    do_reset();
    RegWrite = 1; AIn = 16'd98;
    tick();
    checks++; if (RaOut !== 16'd98 || Depth !== 4'd1) begin
      errors++; $display("FAIL regwr got ra=%0d depth=%0d exp ra=98 depth=1", RaOut, Depth);
    end
    RegWrite = 0; PCWrite = 1; PCSrc = 2'b11;
    tick();
    checks++; if (PCOut !== 16'd98 || Depth !== 4'd0) begin
      errors++; $display("FAIL regwr_ret got pc=%0d depth=%0d exp pc=98 depth=0", PCOut, Depth);
    end
    checks++; if (Underflow !== 1'b0) begin errors++; $display("FAIL regwr_unf got=%b exp=0", Underflow); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Call with RegWrite asserted: the push must win over AIn.
    PCWrite = 1; PCSrc = 2'b10; TargetIn = 16'h0200; Call = 1; RegWrite = 1; AIn = 16'h5555;
    tick();
    RegWrite = 0;
    checks++; if (RaOut !== 16'h0002 || Depth !== 4'd1) begin
      errors++; $display("FAIL push_wins got ra=%h depth=%0d exp ra=0002 depth=1", RaOut, Depth);
    end
    PCSrc = 2'b11; Call = 1;
    tick();
    checks++; if (PCOut !== 16'h0002 || RaOut !== 16'h0202 || Depth !== 4'd1) begin
      errors++; $display("FAIL poppush got pc=%h ra=%h depth=%0d exp 0002 0202 1", PCOut, RaOut, Depth);
    end
    do_reset();
    PCWrite = 1; PCSrc = 2'b11; Call = 1;
    tick();
    checks++; if (PCOut !== 16'h0000 || RaOut !== 16'h0002 || Depth !== 4'd1 || Underflow !== 1'b1) begin
      errors++; $display("FAIL poppush_empty got pc=%h ra=%h depth=%0d unf=%b exp 0000 0002 1 1",
                         PCOut, RaOut, Depth, Underflow);
    end
    idle();
    PCSrc = 2'b11; Call = 1;
    tick();
    checks++; if (PCOut !== 16'h0000 || Depth !== 4'd1) begin
      errors++; $display("FAIL hold_ignores got pc=%h depth=%0d exp 0000 1", PCOut, Depth);
    end
    idle();
  endtask

  initial begin
    Reset = 0;
    idle();
    #2;
    test_reset();
    test_sequential();
    test_call_return();
    test_overflow_underflow();
    test_async_reset();
    test_wrap();
    test_regwrite();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
